// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - sample-in / result-out handshake bundle for layer_sequencer
interface layer_sequencer_if #(
    parameter int NUM_SPIKES  = 784,
    parameter int TIME_PERIOD = 8,
    parameter int NEURONS     = 10
);
    localparam int TW = $clog2(TIME_PERIOD) + 1;
    localparam int NW = $clog2(NEURONS) + 1;

    logic                     smp_valid;
    logic                     smp_ready;
    logic                     smp_train;
    logic [NUM_SPIKES*TW-1:0] smp_times;

    logic                     res_valid;
    logic                     res_ready;
    logic [NW-1:0]            res_neuron;
    logic [TW-1:0]            res_time;

    modport master (
        output smp_valid, smp_train, smp_times, res_ready,
        input  smp_ready, res_valid, res_neuron, res_time
    );

    modport slave (
        input  smp_valid, smp_train, smp_times, res_ready,
        output smp_ready, res_valid, res_neuron, res_time
    );
endinterface

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - steps one spike layer through sample windows; optional done_cnt via LAYER_SEQ_CNT_EN
module layer_sequencer #(
    parameter int NUM_SPIKES  = 784,
    parameter int TIME_PERIOD = 8,
    parameter int NEURONS     = 10,
    localparam int TW = $clog2(TIME_PERIOD) + 1,
    localparam int NW = $clog2(NEURONS) + 1
) (
    input  logic                     clk,
    input  logic                     rst_l,
    layer_sequencer_if.slave         sif,
    output logic [NUM_SPIKES*TW-1:0] spike_times,
    output logic                     training,
    output logic [TW-1:0]            time_val,
    input  logic [NW-1:0]            winning_neuron,
    input  logic [TW-1:0]            output_spike_time,
`ifdef LAYER_SEQ_CNT_EN
    output logic [15:0]              done_cnt,
`endif
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [TW-1:0] LAST_T = TW'(TIME_PERIOD - 1);

    state_t state, next_state;
    logic   last, slot_free, accept, capture, done;

    assign last      = (time_val == LAST_T);
    assign slot_free = !sif.res_valid || sif.res_ready;
    assign accept    = sif.smp_valid && sif.smp_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= next_state;
    end

    // A test window that cannot hand off its winner parks in HOLD with everything frozen.
    always_comb begin
        next_state    = state;
        sif.smp_ready = 1'b0;
        capture       = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                sif.smp_ready = 1'b1;
                if (sif.smp_valid) next_state = RUN;
            end
            RUN: begin
                if (last) begin
                    if (training || slot_free) begin
                        done          = 1'b1;
                        capture       = !training;
                        sif.smp_ready = 1'b1;
                        next_state    = sif.smp_valid ? RUN : IDLE;
                    end else begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (sif.res_ready) begin
                    done          = 1'b1;
                    capture       = 1'b1;
                    sif.smp_ready = 1'b1;
                    next_state    = sif.smp_valid ? RUN : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            time_val    <= '0;
            spike_times <= '0;
            training    <= 1'b0;
        end else begin
            if (done)
                time_val <= '0;
            else if (state == RUN && !last)
                time_val <= time_val + 1'b1;
            if (accept) begin
                spike_times <= sif.smp_times;
                training    <= sif.smp_train;
            end
        end
    end

    // A fresh capture takes priority over the consumer draining the slot.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sif.res_valid  <= 1'b0;
            sif.res_neuron <= '0;
            sif.res_time   <= '0;
        end else if (capture) begin
            sif.res_valid  <= 1'b1;
            sif.res_neuron <= winning_neuron;
            sif.res_time   <= output_spike_time;
        end else if (sif.res_ready) begin
            sif.res_valid  <= 1'b0;
        end
    end

`ifdef LAYER_SEQ_CNT_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)    done_cnt <= '0;
        else if (done) done_cnt <= done_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - self-checking bench for layer_sequencer
module tb_layer_sequencer;
    localparam int NS = 4;
    localparam int TP = 8;
    localparam int NN = 10;
    localparam int TW = $clog2(TP) + 1;
    localparam int NW = $clog2(NN) + 1;
    localparam int SW = NS * TW;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    layer_sequencer_if #(.NUM_SPIKES(NS), .TIME_PERIOD(TP), .NEURONS(NN)) sif ();

    logic [SW-1:0] spike_times;
    logic          training;
    logic [TW-1:0] time_val;
    logic [NW-1:0] winning_neuron;
    logic [TW-1:0] output_spike_time;
    logic          busy;
`ifdef LAYER_SEQ_CNT_EN
    logic [15:0]   done_cnt;
`endif

    layer_sequencer #(.NUM_SPIKES(NS), .TIME_PERIOD(TP), .NEURONS(NN)) dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .sif               (sif),
        .spike_times       (spike_times),
        .training          (training),
        .time_val          (time_val),
        .winning_neuron    (winning_neuron),
        .output_spike_time (output_spike_time),
`ifdef LAYER_SEQ_CNT_EN
        .done_cnt          (done_cnt),
`endif
        .busy              (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic tr, input logic rr,
                         input logic [NW-1:0] wn, input logic [TW-1:0] ot, input logic [SW-1:0] tm);
        @(negedge clk);
        sif.smp_valid     = v;
        sif.smp_train     = tr;
        sif.res_ready     = rr;
        sif.smp_times     = tm;
        winning_neuron    = wn;
        output_spike_time = ot;
        #1;
    endtask

    typedef struct {
        logic          v, tr, rr;
        logic [TW-1:0] exp_t;
        logic          exp_rdy, exp_rv, exp_busy;
        logic [NW-1:0] exp_rn;
        logic [TW-1:0] exp_rt;
    } vec_t;

    vec_t tbl[11];

    // reference model state
    bit            m_act, m_tr, m_rv, m_last, m_cmpl;
    int            m_t, m_cnt;
    logic [SW-1:0] m_times;
    logic [NW-1:0] m_rn;
    logic [TW-1:0] m_rt;

    initial begin
        sif.smp_valid = 1'b0; sif.smp_train = 1'b0; sif.res_ready = 1'b0; sif.smp_times = '0;
        winning_neuron = '0; output_spike_time = '0;

        #12;
        chk("rst_time_val", time_val, 0);
        chk("rst_spikes", spike_times, 0);
        chk("rst_training", training, 0);
        chk("rst_res_valid", sif.res_valid, 0);
        chk("rst_res_neuron", sif.res_neuron, 0);
        chk("rst_res_time", sif.res_time, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); rst_l = 1'b1; #1;
        chk("rst_ready", sif.smp_ready, 1);

        // single test sample, winner 3 at time 5, consumer always ready
        tbl[0] = '{1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b1, TW'(i - 1), (i == 8), 1'b0, 1'b1, 5'd0, 4'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 5'd3, 4'd5};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0};
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].tr, tbl[i].rr, 5'd3, 4'd5, 16'h1234);
            chk($sformatf("tbl%0d_time_val", i), time_val, tbl[i].exp_t);
            chk($sformatf("tbl%0d_ready", i), sif.smp_ready, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_res_valid", i), sif.res_valid, tbl[i].exp_rv);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            if (tbl[i].exp_rv) begin
                chk($sformatf("tbl%0d_res_neuron", i), sif.res_neuron, tbl[i].exp_rn);
                chk($sformatf("tbl%0d_res_time", i), sif.res_time, tbl[i].exp_rt);
            end
        end

        // three back-to-back training samples, valid held through the third window
        for (int c = 0; c <= 25; c++) begin
            drive(c < 24, 1'b1, 1'b1, 5'd1, 4'd1, 16'h0F0F);
            chk("b2b_res_valid", sif.res_valid, 0);
            if (c == 0) begin
                chk("b2b_idle_ready", sif.smp_ready, 1);
            end else if (c <= 24) begin
                chk($sformatf("b2b%0d_time_val", c), time_val, (c - 1) % 8);
                chk($sformatf("b2b%0d_ready", c), sif.smp_ready, ((c - 1) % 8) == 7);
                chk("b2b_busy", busy, 1);
                chk("b2b_training", training, 1);
                chk("b2b_spikes", spike_times, 16'h0F0F);
            end else begin
                chk("b2b_end_busy", busy, 0);
            end
        end

        // two test samples with a stalled consumer, then a release pulse
        for (int c = 0; c <= 23; c++) begin
            drive(c <= 8, 1'b0, (c >= 20) && (c != 21),
                  (c <= 8) ? 5'd7 : 5'd4, (c <= 8) ? 4'd2 : 4'd6, 16'h2222);
            if (c >= 1 && c <= 16) chk($sformatf("hold%0d_time_val", c), time_val, (c - 1) % 8);
            if (c >= 1 && c <= 19) chk($sformatf("hold%0d_busy", c), busy, 1);
            if (c == 8) begin
                chk("hold_first_ready", sif.smp_ready, 1);
                chk("hold_first_rv", sif.res_valid, 0);
            end
            if (c >= 9 && c <= 19) begin
                chk($sformatf("hold%0d_ready", c), sif.smp_ready, 0);
                chk($sformatf("hold%0d_rv", c), sif.res_valid, 1);
                chk($sformatf("hold%0d_rn", c), sif.res_neuron, 7);
                chk($sformatf("hold%0d_rt", c), sif.res_time, 2);
            end
            if (c >= 17 && c <= 19) chk($sformatf("hold%0d_frozen_t", c), time_val, 7);
            if (c == 20) begin
                chk("hold_release_ready", sif.smp_ready, 1);
                chk("hold_release_rn", sif.res_neuron, 7);
            end
            if (c == 21) begin
                chk("hold_second_rv", sif.res_valid, 1);
                chk("hold_second_rn", sif.res_neuron, 4);
                chk("hold_second_rt", sif.res_time, 6);
                chk("hold_second_busy", busy, 0);
                chk("hold_second_t", time_val, 0);
            end
            if (c == 22) chk("hold_drain_rv_before", sif.res_valid, 1);
            if (c == 23) chk("hold_drain_rv_after", sif.res_valid, 0);
        end

        // reset in the middle of a test window
        for (int c = 0; c <= 5; c++) drive(c == 0, 1'b0, 1'b1, 5'd9, 4'd3, 16'hA5C3);
        chk("abort_pre_t", time_val, 4);
        chk("abort_pre_spikes", spike_times, 16'hA5C3);
        rst_l = 1'b0; #1;
        chk("abort_time_val", time_val, 0);
        chk("abort_spikes", spike_times, 0);
        chk("abort_training", training, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rv", sif.res_valid, 0);
        chk("abort_rn", sif.res_neuron, 0);
        chk("abort_rt", sif.res_time, 0);
        @(negedge clk); rst_l = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b0, 1'b1, 5'd9, 4'd3, 16'h0);
            chk("abort_post_rv", sif.res_valid, 0);
            chk("abort_post_busy", busy, 0);
        end

        // randomized traffic against the window/slot model
        m_act = 0; m_tr = 0; m_rv = 0; m_t = 0; m_cnt = 0; m_times = '0; m_rn = '0; m_rt = '0;
        for (int i = 0; i < 3000; i++) begin
            logic v, tr, rr;
            logic [NW-1:0] wn;
            logic [TW-1:0] ot;
            logic [SW-1:0] tm;
            v  = ($urandom % 3) != 0;
            tr = $urandom % 2;
            rr = ((i / 500) % 3 == 0) ? 1'b1 : (($urandom % (((i / 500) % 3 == 1) ? 2 : 12)) == 0);
            wn = NW'($urandom_range(0, NN - 1));
            ot = TW'($urandom_range(0, TP - 1));
            tm = SW'($urandom);
            drive(v, tr, rr, wn, ot, tm);

            m_last = m_act && (m_t == TP - 1);
            m_cmpl = m_last && (m_tr || !m_rv || rr);
            chk("rnd_ready", sif.smp_ready, !m_act || m_cmpl);
            chk("rnd_time_val", time_val, m_t);
            chk("rnd_busy", busy, m_act);
            chk("rnd_training", training, m_tr);
            chk("rnd_spikes", spike_times, m_times);
            chk("rnd_res_valid", sif.res_valid, m_rv);
            if (m_rv) begin
                chk("rnd_res_neuron", sif.res_neuron, m_rn);
                chk("rnd_res_time", sif.res_time, m_rt);
            end
`ifdef LAYER_SEQ_CNT_EN
            chk("rnd_done_cnt", done_cnt, m_cnt % 65536);
`endif
            if (m_cmpl && !m_tr) begin
                m_rv = 1; m_rn = wn; m_rt = ot;
            end else if (rr) begin
                m_rv = 0;
            end
            if (m_cmpl) m_cnt++;
            if (v && (!m_act || m_cmpl)) begin
                m_act = 1; m_t = 0; m_tr = tr; m_times = tm;
            end else if (m_cmpl) begin
                m_act = 0; m_t = 0;
            end else if (m_act && !m_last) begin
                m_t++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_SPIKES, default 784, input spike lines per sample.
REQ-002 Parameter TIME_PERIOD, default 8, cycles per sample window.
REQ-003 Parameter NEURONS, default 10, neurons in the driven layer; TW = clog2(TIME_PERIOD)+1, NW = clog2(NEURONS)+1.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_l  in  1  asynchronous active-low reset.
REQ-006 smp_valid  in  1  sample offered.
REQ-007 smp_ready  out  1  sequencer accepts sample this cycle.
REQ-008 smp_train  in  1  1 = training sample, 0 = test sample; qualified by smp_valid.
REQ-009 smp_times  in  NUM_SPIKES*TW  per-line spike times of offered sample.
REQ-010 spike_times  out  NUM_SPIKES*TW  registered spike times driven to layer.
REQ-011 training  out  1  registered mode driven to layer.
REQ-012 time_val  out  TW  window time step driven to layer.
REQ-013 winning_neuron  in  NW  layer winner.
REQ-014 output_spike_time  in  TW  layer winner spike time.
REQ-015 res_valid  out  1  test result available.
REQ-016 res_ready  in  1  result consumed.
REQ-017 res_neuron  out  NW; res_time  out  TW  captured result.
REQ-018 busy  out  1  high when state != IDLE.

Function
REQ-019 States IDLE, RUN, HOLD; accept = smp_valid && smp_ready.
REQ-020 IDLE: time_val = 0; smp_ready = 1; accept loads spike_times/training, next state RUN, time_val 0 on first RUN cycle.
REQ-021 RUN: time_val increments by 1 per cycle, 0..TIME_PERIOD-1; last = (time_val == TIME_PERIOD-1).
REQ-022 slot_free = !res_valid || res_ready; on last cycle of a test sample the winner SHALL be captured only if slot_free.
REQ-023 Last cycle, training or slot_free: capture (test only) sets res_valid, res_neuron = winning_neuron, res_time = output_spike_time; smp_ready = 1; accept -> RUN, time_val wraps to 0 (zero-gap back-to-back); no accept -> IDLE.
REQ-024 Last cycle, test and !slot_free: smp_ready = 0, next HOLD; time_val, spike_times, training frozen.
REQ-025 HOLD: when res_ready, capture winner in that cycle, res_valid stays 1 with new data, smp_ready = 1, same next-state rule as REQ-023.
REQ-026 smp_ready = 0 in RUN except last cycle; spike_times/training change only on accept.
REQ-027 res_valid clears on res_valid && res_ready unless a new capture occurs same cycle (capture wins).
REQ-028 res_neuron/res_time stable while res_valid && !res_ready.
REQ-029 Training samples never assert or modify the result.
REQ-030 TIME_PERIOD = 1: every RUN cycle is last; REQ-023/024 apply.

Reset
REQ-031 rst_l low: state IDLE, time_val 0, spike_times 0, training 0, res_valid 0, res_neuron 0, res_time 0, busy 0, smp_ready 1 after release.
REQ-032 Reset mid-window or in HOLD aborts sample and discards pending result; no partial result emitted.

Configuration
REQ-033 LAYER_SEQ_CNT_EN defined: adds output done_cnt (16 bits), reset 0, +1 per completed sample (train or test) at window completion, wraps 65535 -> 0.
REQ-034 LAYER_SEQ_CNT_EN undefined: done_cnt port and logic absent; all other behaviour identical.

Verification (TIME_PERIOD=8)
REQ-035 Single test sample, res_ready=1, winner 3 time 5 -> time_val 0..7, res_valid one cycle after time_val 7, res_neuron 3, res_time 5, then IDLE.
REQ-036 Three back-to-back train samples, smp_valid held 1 -> time_val 0..7 x3 contiguous, smp_ready high only at time_val 7, res_valid never 1.
REQ-037 Two test samples, res_ready=0 for 20 cycles -> first result held, second window stops at time_val 7 in HOLD, smp_ready 0; res_ready pulse -> second result captured, res_valid stays 1.
REQ-038 rst_l low at time_val 4 of test sample -> all outputs 0 immediately, no res_valid after release.
REQ-039 LAYER_SEQ_CNT_EN, done_cnt preset path 65535 via 65536 samples -> done_cnt wraps to 0.
